// File: rtl/mips_mc_ctrl_pkg.sv
// Shared opcode/funct constants, ALU operation codes and control FSM states
// for the multicycle MIPS controller.
package AluCtrlSig_pkg;

    localparam logic [5:0] ADD_op  = 6'h00;  // R-type
    localparam logic [5:0] J_op    = 6'h02;
    localparam logic [5:0] BEQ_op  = 6'h04;
    localparam logic [5:0] BNE_op  = 6'h05;
    localparam logic [5:0] ADDI_op = 6'h08;
    localparam logic [5:0] LW_op   = 6'h23;
    localparam logic [5:0] SW_op   = 6'h2B;

    localparam logic [5:0] ADD_funct = 6'h20;
    localparam logic [5:0] SUB_funct = 6'h22;
    localparam logic [5:0] AND_funct = 6'h24;
    localparam logic [5:0] OR_funct  = 6'h25;
    localparam logic [5:0] XOR_funct = 6'h26;
    localparam logic [5:0] NOR_funct = 6'h27;
    localparam logic [5:0] SLT_funct = 6'h2A;

    typedef enum logic [3:0] {
        ALU_AND = 4'd0,
        ALU_OR  = 4'd1,
        ALU_ADD = 4'd2,
        ALU_SUB = 4'd6,
        ALU_SLT = 4'd7,
        ALU_NOR = 4'd12,
        ALU_XOR = 4'd13
    } alu_op_t;

    typedef enum logic [3:0] {
        S_RST     = 4'd0,
        S_FETCH   = 4'd1,
        S_DECODE  = 4'd2,
        S_MEMADR  = 4'd3,
        S_MEMRD   = 4'd4,
        S_MEMWB   = 4'd5,
        S_MEMWR   = 4'd6,
        S_RTYPEEX = 4'd7,
        S_RTYPEWB = 4'd8,
        S_ADDIEX  = 4'd9,
        S_ADDIWB  = 4'd10,
        S_BRANCH  = 4'd11,
        S_JUMP    = 4'd12
    } ctrl_state_t;

endpackage

// File: rtl/mips_mc_ctrl_alu_dec.sv
// Combinational R-type funct decoder: ALU operation plus a flag telling
// whether the funct is one the datapath supports.
module alu_dec
    import AluCtrlSig_pkg::*;
(
    input  logic [5:0] funct,
    output logic [3:0] alu_ctrl,
    output logic       valid
);

    always_comb begin
        alu_ctrl = ALU_AND;
        valid    = 1'b1;
        case (funct)
            ADD_funct: alu_ctrl = ALU_ADD;
            SUB_funct: alu_ctrl = ALU_SUB;
            AND_funct: alu_ctrl = ALU_AND;
            OR_funct:  alu_ctrl = ALU_OR;
            NOR_funct: alu_ctrl = ALU_NOR;
            SLT_funct: alu_ctrl = ALU_SLT;
            XOR_funct: alu_ctrl = ALU_XOR;
            default:   valid    = 1'b0;
        endcase
    end

endmodule

// File: rtl/mips_mc_ctrl.sv
// Multicycle MIPS control FSM with memory wait states, illegal-instruction
// flagging and a retired-instruction counter.
module mips_mc_ctrl
    import AluCtrlSig_pkg::*;
#(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      instr,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             pcEn,
    output logic             irWrite,
    output logic             regWrite,
    output logic             memRead,
    output logic             memWrite,
    output logic             iorD,
    output logic             memToReg,
    output logic             regDst,
    output logic             aluSrcA,
    output logic [1:0]       aluSrcB,
    output logic [1:0]       pcSrc,
    output logic [3:0]       aluCtrl,
    output logic             instr_done,
    output logic             illegal,
    output logic [CNT_W-1:0] instr_cnt
);

    ctrl_state_t state;
    ctrl_state_t state_next;

    logic [5:0] opcode;
    logic [5:0] funct;
    logic [3:0] funct_alu;
    logic       funct_valid;
    logic       op_legal;
    logic       unused_instr_bits;

    assign opcode            = instr[31:26];
    assign funct             = instr[5:0];
    assign unused_instr_bits = ^instr[25:6];

    alu_dec u_alu_dec (
        .funct    (funct),
        .alu_ctrl (funct_alu),
        .valid    (funct_valid)
    );

    always_comb begin
        op_legal = 1'b0;
        case (opcode)
            LW_op, SW_op, J_op, BEQ_op, BNE_op, ADDI_op: op_legal = 1'b1;
            ADD_op:                                      op_legal = funct_valid;
            default:                                     op_legal = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_RST;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_RST:     state_next = S_FETCH;
            S_FETCH:   if (mem_ready) state_next = S_DECODE;
            S_DECODE: begin
                if (!op_legal) begin
                    state_next = S_FETCH;
                end else begin
                    case (opcode)
                        LW_op, SW_op:   state_next = S_MEMADR;
                        ADD_op:         state_next = S_RTYPEEX;
                        ADDI_op:        state_next = S_ADDIEX;
                        BEQ_op, BNE_op: state_next = S_BRANCH;
                        J_op:           state_next = S_JUMP;
                        default:        state_next = S_FETCH;
                    endcase
                end
            end
            S_MEMADR:  state_next = (opcode == LW_op) ? S_MEMRD : S_MEMWR;
            S_MEMRD:   if (mem_ready) state_next = S_MEMWB;
            S_MEMWR:   if (mem_ready) state_next = S_FETCH;
            S_RTYPEEX: state_next = S_RTYPEWB;
            S_ADDIEX:  state_next = S_ADDIWB;
            S_MEMWB, S_RTYPEWB, S_ADDIWB, S_BRANCH, S_JUMP:
                       state_next = S_FETCH;
            default:   state_next = S_RST;
        endcase
    end

    // Outputs follow the state; mem_ready, zero and opcode only gate a few of them.
    always_comb begin
        pcEn       = 1'b0;
        irWrite    = 1'b0;
        regWrite   = 1'b0;
        memRead    = 1'b0;
        memWrite   = 1'b0;
        iorD       = 1'b0;
        memToReg   = 1'b0;
        regDst     = 1'b0;
        aluSrcA    = 1'b0;
        aluSrcB    = 2'b00;
        pcSrc      = 2'b00;
        aluCtrl    = '0;
        instr_done = 1'b0;
        illegal    = 1'b0;
        case (state)
            S_FETCH: begin
                memRead = 1'b1;
                aluSrcB = 2'b01;
                aluCtrl = ALU_ADD;
                irWrite = mem_ready;
                pcEn    = mem_ready;
            end
            S_DECODE: begin
                aluSrcB = 2'b11;
                aluCtrl = ALU_ADD;
                illegal = ~op_legal;
            end
            S_MEMADR, S_ADDIEX: begin
                aluSrcA = 1'b1;
                aluSrcB = 2'b10;
                aluCtrl = ALU_ADD;
            end
            S_MEMRD: begin
                memRead = 1'b1;
                iorD    = 1'b1;
            end
            S_MEMWB: begin
                regWrite   = 1'b1;
                memToReg   = 1'b1;
                instr_done = 1'b1;
            end
            S_MEMWR: begin
                memWrite   = 1'b1;
                iorD       = 1'b1;
                instr_done = mem_ready;
            end
            S_RTYPEEX: begin
                aluSrcA = 1'b1;
                aluCtrl = funct_alu;
            end
            S_RTYPEWB: begin
                regWrite   = 1'b1;
                regDst     = 1'b1;
                aluCtrl    = funct_alu;
                instr_done = 1'b1;
            end
            S_ADDIWB: begin
                regWrite   = 1'b1;
                instr_done = 1'b1;
            end
            S_BRANCH: begin
                aluSrcA    = 1'b1;
                aluCtrl    = ALU_SUB;
                pcSrc      = 2'b01;
                pcEn       = (opcode == BNE_op) ? ~zero : zero;
                instr_done = 1'b1;
            end
            S_JUMP: begin
                pcSrc      = 2'b10;
                pcEn       = 1'b1;
                instr_done = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            instr_cnt <= '0;
        end else if (instr_done) begin
            instr_cnt <= instr_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_mips_mc_ctrl.sv
// Bench for mips_mc_ctrl: per-instruction expected control-word sequences are
// built from the instruction class and chosen wait states, then compared every cycle.
module tb_mips_mc_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] instr = '0;
    logic        zero = 1'b0;
    logic        mem_ready = 1'b0;
    logic        pcEn, irWrite, regWrite, memRead, memWrite, iorD;
    logic        memToReg, regDst, aluSrcA;
    logic [1:0]  aluSrcB, pcSrc;
    logic [3:0]  aluCtrl;
    logic        instr_done, illegal;
    logic [31:0] instr_cnt;

    mips_mc_ctrl #(.CNT_W(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .instr      (instr),
        .zero       (zero),
        .mem_ready  (mem_ready),
        .pcEn       (pcEn),
        .irWrite    (irWrite),
        .regWrite   (regWrite),
        .memRead    (memRead),
        .memWrite   (memWrite),
        .iorD       (iorD),
        .memToReg   (memToReg),
        .regDst     (regDst),
        .aluSrcA    (aluSrcA),
        .aluSrcB    (aluSrcB),
        .pcSrc      (pcSrc),
        .aluCtrl    (aluCtrl),
        .instr_done (instr_done),
        .illegal    (illegal),
        .instr_cnt  (instr_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       pc_en, ir_write, reg_write, mem_read, mem_write, ior_d;
        logic       mem_to_reg, reg_dst, alu_src_a;
        logic [1:0] alu_src_b, pc_src;
        logic [3:0] alu_ctrl;
        logic       done, illegal;
    } ctl_t;

    typedef struct {
        ctl_t w;
        logic mr;
        logic z;
    } entry_t;

    entry_t      exp_q[$];
    ctl_t        dut_hist[16];
    int          n_pass = 0;
    int          n_total = 0;
    logic [31:0] cnt_exp = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got %h, expected %h", name, act, exp);
        else n_pass++;
    endtask

    function automatic logic rbit();
        return 1'($urandom);
    endfunction

    function automatic ctl_t dut_word();
        ctl_t w;
        w.pc_en = pcEn;       w.ir_write = irWrite;   w.reg_write = regWrite;
        w.mem_read = memRead; w.mem_write = memWrite; w.ior_d = iorD;
        w.mem_to_reg = memToReg; w.reg_dst = regDst;  w.alu_src_a = aluSrcA;
        w.alu_src_b = aluSrcB; w.pc_src = pcSrc;      w.alu_ctrl = aluCtrl;
        w.done = instr_done;  w.illegal = illegal;
        return w;
    endfunction

    function automatic void funct_map(input logic [5:0] f, output logic [3:0] a, output bit ok);
        ok = 1'b1;
        case (f)
            6'h20: a = 4'd2;
            6'h22: a = 4'd6;
            6'h24: a = 4'd0;
            6'h25: a = 4'd1;
            6'h27: a = 4'd12;
            6'h2A: a = 4'd7;
            6'h26: a = 4'd13;
            default: begin a = 4'd0; ok = 1'b0; end
        endcase
    endfunction

    function automatic void push(input ctl_t w, input logic mr, input logic z);
        entry_t e;
        e.w = w; e.mr = mr; e.z = z;
        exp_q.push_back(e);
    endfunction

    // Expected cycle-by-cycle control words for one instruction.
    // fw/mw: wait cycles in fetch / data access; zsel < 0 picks zero at random.
    function automatic void build(input logic [31:0] ins, input int fw, input int mw, input int zsel);
        ctl_t       w;
        logic [5:0] op = ins[31:26];
        logic [3:0] fa;
        bit         fok;
        bit         legal;
        logic       z;
        exp_q.delete();
        for (int k = 0; k <= fw; k++) begin
            w = '0; w.mem_read = 1'b1; w.alu_src_b = 2'b01; w.alu_ctrl = 4'd2;
            if (k == fw) begin w.ir_write = 1'b1; w.pc_en = 1'b1; end
            push(w, (k == fw), rbit());
        end
        funct_map(ins[5:0], fa, fok);
        legal = (op == 6'h23) || (op == 6'h2B) || (op == 6'h02) || (op == 6'h04) ||
                (op == 6'h05) || (op == 6'h08) || (op == 6'h00 && fok);
        w = '0; w.alu_src_b = 2'b11; w.alu_ctrl = 4'd2; w.illegal = !legal;
        push(w, rbit(), rbit());
        if (!legal) return;
        case (op)
            6'h23, 6'h2B: begin
                w = '0; w.alu_src_a = 1'b1; w.alu_src_b = 2'b10; w.alu_ctrl = 4'd2;
                push(w, rbit(), rbit());
                for (int k = 0; k <= mw; k++) begin
                    w = '0; w.ior_d = 1'b1;
                    if (op == 6'h23) w.mem_read = 1'b1;
                    else begin w.mem_write = 1'b1; w.done = (k == mw); end
                    push(w, (k == mw), rbit());
                end
                if (op == 6'h23) begin
                    w = '0; w.reg_write = 1'b1; w.mem_to_reg = 1'b1; w.done = 1'b1;
                    push(w, rbit(), rbit());
                end
            end
            6'h00: begin
                w = '0; w.alu_src_a = 1'b1; w.alu_ctrl = fa;
                push(w, rbit(), rbit());
                w = '0; w.reg_write = 1'b1; w.reg_dst = 1'b1; w.alu_ctrl = fa; w.done = 1'b1;
                push(w, rbit(), rbit());
            end
            6'h08: begin
                w = '0; w.alu_src_a = 1'b1; w.alu_src_b = 2'b10; w.alu_ctrl = 4'd2;
                push(w, rbit(), rbit());
                w = '0; w.reg_write = 1'b1; w.done = 1'b1;
                push(w, rbit(), rbit());
            end
            6'h04, 6'h05: begin
                z = (zsel < 0) ? rbit() : zsel[0];
                w = '0; w.alu_src_a = 1'b1; w.alu_ctrl = 4'd6; w.pc_src = 2'b01; w.done = 1'b1;
                w.pc_en = (op == 6'h04) ? z : !z;
                push(w, rbit(), z);
            end
            default: begin
                w = '0; w.pc_src = 2'b10; w.pc_en = 1'b1; w.done = 1'b1;
                push(w, rbit(), rbit());
            end
        endcase
    endfunction

    // Drive the prepared sequence; pin_cnt >= 0 also pins instr_cnt on cycle 0.
    task automatic run_seq(input logic [31:0] ins, input int limit, input int pin_cnt);
        int n;
        n = (limit < exp_q.size()) ? limit : exp_q.size();
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            instr = ins; mem_ready = exp_q[i].mr; zero = exp_q[i].z;
            @(negedge clk);
            if (i < 16) dut_hist[i] = dut_word();
            chk($sformatf("ctl[%0d] instr=%h", i, ins), 32'(dut_word()), 32'(exp_q[i].w));
            chk("instr_cnt", instr_cnt, cnt_exp);
            if (i == 0 && pin_cnt >= 0) chk("cnt_pin", instr_cnt, 32'(pin_cnt));
            if (exp_q[i].w.done) cnt_exp = cnt_exp + 1;
        end
    endtask

    task automatic release_reset();
        @(posedge clk);
        #1 rst = 1'b0;
        cnt_exp = '0;
        @(negedge clk);
        chk("srst_outputs", 32'(dut_word()), 32'd0);
        chk("srst_cnt", instr_cnt, 32'd0);
    endtask

    initial begin
        logic [5:0]  ops [10];
        logic [5:0]  fns [7];
        logic [5:0]  op, fn;
        logic [31:0] ins;
        int          tot;
        ops = '{6'h23, 6'h2B, 6'h02, 6'h04, 6'h05, 6'h08, 6'h00, 6'h00, 6'h3F, 6'h11};
        fns = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h27, 6'h2A, 6'h26};

        @(negedge clk);
        chk("rst_outputs", 32'(dut_word()), 32'd0);
        chk("rst_cnt", instr_cnt, 32'd0);
        release_reset();

        build(32'h012A4020, 0, 0, -1);
        chk("add_len", exp_q.size(), 32'd4);
        run_seq(32'h012A4020, 99, -1);
        chk("add_ex_aluctrl", 32'(dut_hist[2].alu_ctrl), 32'd2);
        chk("add_wb_regdst", 32'(dut_hist[3].reg_dst & dut_hist[3].reg_write), 32'd1);

        build(32'h8D090004, 0, 2, -1);
        chk("lw_len", exp_q.size(), 32'd7);
        run_seq(32'h8D090004, 99, 1);
        tot = 0;
        for (int i = 0; i < 7; i++) tot += dut_hist[i].mem_to_reg + dut_hist[i].reg_write;
        chk("lw_memtoreg_only_wb", 32'(tot), 32'd2);
        chk("lw_wb_memtoreg", 32'(dut_hist[6].mem_to_reg), 32'd1);

        build(32'h11090003, 0, 0, 1);
        chk("beq_len", exp_q.size(), 32'd3);
        run_seq(32'h11090003, 99, 2);
        chk("beq_pcen", 32'(dut_hist[2].pc_en), 32'd1);
        chk("beq_pcsrc", 32'(dut_hist[2].pc_src), 32'd1);

        build(32'h15090003, 0, 0, 1);
        run_seq(32'h15090003, 99, 3);
        chk("bne_pcen", 32'(dut_hist[2].pc_en), 32'd0);

        build(32'hFC000000, 0, 0, -1);
        chk("illop_len", exp_q.size(), 32'd2);
        run_seq(32'hFC000000, 99, 4);
        chk("illop_flag", 32'(dut_hist[1].illegal), 32'd1);

        build(32'h012A4018, 0, 0, -1);
        run_seq(32'h012A4018, 99, 4);
        chk("illfn_flag", 32'(dut_hist[1].illegal), 32'd1);

        build(32'hAD090004, 0, 0, -1);
        chk("sw_len", exp_q.size(), 32'd4);
        run_seq(32'hAD090004, 99, 4);

        for (int n = 0; n < 250; n++) begin
            op = ops[$urandom_range(9)];
            fn = ($urandom_range(3) != 0) ? fns[$urandom_range(6)] : 6'($urandom);
            ins = {op, 20'($urandom), fn};
            build(ins, $urandom_range(2), $urandom_range(2), -1);
            run_seq(ins, 99, -1);
        end

        // Abort a store while it is waiting on memory.
        build(32'hAD090004, 0, 3, -1);
        run_seq(32'hAD090004, 4, -1);
        chk("midsw_memwrite_before", 32'(memWrite), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("midsw_outputs", 32'(dut_word()), 32'd0);
        chk("midsw_cnt", instr_cnt, 32'd0);
        release_reset();

        for (int n = 0; n < 20; n++) begin
            op = ops[$urandom_range(9)];
            ins = {op, 20'($urandom), fns[$urandom_range(6)]};
            build(ins, $urandom_range(1), $urandom_range(1), -1);
            run_seq(ins, 99, -1);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/mips_mc_ctrl.md
# mips_mc_ctrl

Multicycle control FSM for the MIPS datapath. Sequences fetch, decode, execute, memory and writeback for LW, SW, J, BEQ, BNE, ADDI and R-type ADD/SUB/AND/OR/NOR/SLT/XOR. Drives every datapath enable and mux select, and produces `pcEn` for the downstream checker. Adds memory wait-state handshaking, illegal-instruction flagging and a retired-instruction counter.

## Interface
- `CNT_W`, default 32: width of the retired-instruction counter.

- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `instr` in 32: current IR contents; the FSM uses `[31:26]` (opcode) and `[5:0]` (funct).
- `zero` in 1: ALU zero flag.
- `mem_ready` in 1: memory access completes in this cycle.
- `pcEn` out 1: PC write enable.
- `irWrite`, `regWrite`, `memRead`, `memWrite` out 1 each: datapath enables.
- `iorD`, `memToReg`, `regDst`, `aluSrcA` out 1 each: mux selects.
- `aluSrcB` out 2: 00 = B reg, 01 = const 4, 10 = sign-extended imm, 11 = sign-extended imm<<2.
- `pcSrc` out 2: 00 = ALU result, 01 = ALUOut, 10 = jump target.
- `aluCtrl` out 4: ALU op code.
- `instr_done` out 1: one-cycle pulse on the final cycle of each retired instruction.
- `illegal` out 1: one-cycle pulse when an unsupported opcode or funct is seen in DECODE.
- `instr_cnt` out `CNT_W`: count of retired instructions.

## Operation
- Moore FSM. Outputs decode from the state, except for gating by `mem_ready`, `zero` and the opcode as listed.
- **S_RST**: all outputs 0. Next state is FETCH.
- **FETCH**: memRead=1, iorD=0, aluSrcA=0, aluSrcB=01, aluCtrl=ADD, pcSrc=00.
  - irWrite and pcEn are asserted only when `mem_ready`=1.
  - If `mem_ready`=0, stay in FETCH; otherwise go to DECODE.
- **DECODE**: aluSrcA=0, aluSrcB=11, aluCtrl=ADD. This precomputes the branch target into ALUOut.
  - Next state by opcode: LW/SW → MEMADR, R-type → RTYPEEX, ADDI → ADDIEX, BEQ/BNE → BRANCH, J → JUMP.
  - Any other opcode, or an R-type with an unsupported funct: illegal=1, next state FETCH, no writes, no count.
- **MEMADR**: aluSrcA=1, aluSrcB=10, ADD. Next state is MEMRD (LW) or MEMWR (SW).
- **MEMRD**: memRead=1, iorD=1. Hold until `mem_ready`, then go to MEMWB.
- **MEMWB**: regWrite=1, regDst=0, memToReg=1, instr_done=1. Next state FETCH.
- **MEMWR**: iorD=1.
  - memWrite=1 in every cycle of the state.
  - instr_done=1 only in the cycle where `mem_ready`=1; next state FETCH on `mem_ready`.
- **RTYPEEX**: aluSrcA=1, aluSrcB=00, aluCtrl=funct decode. Next state RTYPEWB.
- **RTYPEWB**: regWrite=1, regDst=1, memToReg=0, aluCtrl held from RTYPEEX, instr_done=1.
- **ADDIEX**: aluSrcA=1, aluSrcB=10, ADD. Next state ADDIWB.
- **ADDIWB**: regWrite=1, regDst=0, memToReg=0, instr_done=1.
- **BRANCH**: aluSrcA=1, aluSrcB=00, aluCtrl=SUB, pcSrc=01, instr_done=1.
  - pcEn = `zero` for BEQ, `~zero` for BNE.
- **JUMP**: pcSrc=10, pcEn=1, instr_done=1.
- After WB, BRANCH, JUMP and completed MEMWR the next state is FETCH.
- ALU codes: ADD=2, SUB=6, AND=0, OR=1, NOR=12, SLT=7, XOR=13.
- Funct map: 0x20 ADD, 0x22 SUB, 0x24 AND, 0x25 OR, 0x27 NOR, 0x2A SLT, 0x26 XOR.
- `instr_cnt` increments by 1 on each cycle with instr_done=1. It wraps modulo 2^`CNT_W`.

## Timing
- Reset values: state S_RST, `instr_cnt`=0, every output 0.
- Reset asserted mid-instruction aborts it immediately, with no pending write.
- Cycles per instruction with zero wait states: LW 5, SW 4, R-type 4, ADDI 4, BEQ/BNE 3, J 3, illegal 2. Each `mem_ready`=0 cycle adds one cycle.
- `instr_done` and the counter update on the same edge. `instr_cnt` shows the new value one cycle after the pulse.
- `mem_ready` is sampled only in FETCH, MEMRD and MEMWR. It is ignored elsewhere.

## Structure
- Shared package `AluCtrlSig_pkg` holds:
  - opcode constants `LW_op`, `SW_op`, `J_op`, `BEQ_op`, `BNE_op`, `ADDI_op`, `ADD_op`;
  - funct constants;
  - the 4-bit ALU op enum;
  - new `ctrl_state_t` enum.
- Sub-module `alu_dec` is combinational: funct → aluCtrl plus a valid flag. It is used in DECODE for illegal detection and in RTYPEEX/RTYPEWB for aluCtrl.

## Test plan
- **Reset**: rst=1 then release. All outputs 0, `instr_cnt`=0; FETCH follows one cycle after S_RST.
- **ADD**: `instr`=0x012A4020, `mem_ready`=1.
  - 4 cycles; aluCtrl=2 in EX.
  - regWrite=1 and regDst=1 in WB; instr_done pulses once; `instr_cnt`=1.
- **LW with wait states**: `instr`=0x8D090004, `mem_ready` low for 2 cycles in MEMRD. 7 cycles total; memToReg=1 and regWrite=1 only in MEMWB.
- **BEQ/BNE**:
  - BEQ (0x11090003) with zero=1 → pcEn=1, pcSrc=01 in BRANCH.
  - BNE (0x15090003) with zero=1 → pcEn=0. Each takes 3 cycles.
- **Illegal**:
  - Opcode 0x3F → illegal pulse in DECODE, back to FETCH, `instr_cnt` unchanged.
  - R-type with funct 0x18 → same behaviour.
- **Reset mid-SW**: rst asserted during MEMWR with `mem_ready`=0. memWrite drops asynchronously; the FSM restarts through S_RST; `instr_cnt`=0.
